// File: rtl/seg_capture.sv
// seg_capture: reads a multiplexed seven-segment bus back into hex frames.
//
// Each digit's {segments,dp} pattern must be seen STABLE consecutive times
// (counting only samples where exactly one digit enable is asserted) before
// it is decoded and committed into a per-digit staging slot. When every
// digit has committed, the staging slots are copied to the frame outputs and
// presented downstream.
//
// Handshake: frame_valid/frame_ready follow strict valid/ready rules. A frame
// transfers on any rising edge where both are high. Once frame_valid is high,
// frame_hex/frame_dp/frame_bad hold their values until that transfer.
// frame_ready is ignored while frame_valid is low.
//
// Build option: define SEG_CAPTURE_ACTIVE_LOW_EN for a common-anode bus. The
// seg, dp and dig_en pins are then inverted at the input register, and all
// logic after that register works on active-high values.
module seg_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg,
  input  logic                dp,
  input  logic [NDIG-1:0]     dig_en,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [4*NDIG-1:0]   frame_hex,
  output logic [NDIG-1:0]     frame_dp,
  output logic [NDIG-1:0]     frame_bad
);

  // Counter wide enough to hold STABLE itself.
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  // ---------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------
  logic [6:0]      seg_in;
  logic            dp_in;
  logic [NDIG-1:0] en_in;

`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
  assign seg_in = ~seg;
  assign dp_in  = ~dp;
  assign en_in  = ~dig_en;
`else
  assign seg_in = seg;
  assign dp_in  = dp;
  assign en_in  = dig_en;
`endif

  logic [6:0]      seg_q;
  logic            dp_q;
  logic [NDIG-1:0] en_q;

  // Register the bus pins before any use.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      en_q  <= '0;
    end else begin
      seg_q <= seg_in;
      dp_q  <= dp_in;
      en_q  <= en_in;
    end
  end

  // A sample is usable only when exactly one digit enable is set. The check
  // clears the lowest set bit and tests that nothing remains.
  logic en_onehot;
  assign en_onehot = (en_q != '0) && ((en_q & (en_q - NDIG'(1))) == '0);

  // ---------------------------------------------------------------------
  // Pattern decode: returns {bad, nibble}. Unknown patterns give nibble 0
  // with bad set.
  // ---------------------------------------------------------------------
  function automatic logic [4:0] encode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h4E:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [4:0] enc_w;
  assign enc_w = encode(seg_q);

  // ---------------------------------------------------------------------
  // Per-digit stability tracking
  // ---------------------------------------------------------------------
  logic [6:0]      last_pat_q [NDIG];
  logic [6:0]      last_pat_d [NDIG];
  logic [NDIG-1:0] last_dp_q, last_dp_d;
  logic [CW-1:0]   cnt_q [NDIG];
  logic [CW-1:0]   cnt_d [NDIG];
  logic [CW-1:0]   cnt_nx;
  logic [NDIG-1:0] commit;

  // Update the active digit's run count. A differing pattern restarts the
  // run at 1. Reaching STABLE commits the digit and clears the count, so a
  // steady display recommits every STABLE active samples.
  always_comb begin
    last_dp_d = last_dp_q;
    commit    = '0;
    cnt_nx    = '0;
    for (int k = 0; k < NDIG; k++) begin
      last_pat_d[k] = last_pat_q[k];
      cnt_d[k]      = cnt_q[k];
    end
    for (int k = 0; k < NDIG; k++) begin
      if (en_onehot && en_q[k]) begin
        if ({seg_q, dp_q} == {last_pat_q[k], last_dp_q[k]}) begin
          cnt_nx = cnt_q[k] + CW'(1);
        end else begin
          last_pat_d[k] = seg_q;
          last_dp_d[k]  = dp_q;
          cnt_nx        = CW'(1);
        end
        if (cnt_nx == STABLE_C) begin
          commit[k] = 1'b1;
          cnt_d[k]  = '0;
        end else begin
          cnt_d[k]  = cnt_nx;
        end
      end
    end
  end

  // Per-digit pattern history and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dp_q <= '0;
      for (int k = 0; k < NDIG; k++) begin
        last_pat_q[k] <= '0;
        cnt_q[k]      <= '0;
      end
    end else begin
      last_dp_q <= last_dp_d;
      for (int k = 0; k < NDIG; k++) begin
        last_pat_q[k] <= last_pat_d[k];
        cnt_q[k]      <= cnt_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Staging and frame assembly
  // ---------------------------------------------------------------------
  logic [4*NDIG-1:0] stg_hex_q, stg_hex_d;
  logic [NDIG-1:0]   stg_dp_q, stg_dp_d;
  logic [NDIG-1:0]   stg_bad_q, stg_bad_d;
  logic [NDIG-1:0]   done_q, done_d;

  logic              frame_valid_q, frame_valid_d;
  logic [4*NDIG-1:0] frame_hex_q, frame_hex_d;
  logic [NDIG-1:0]   frame_dp_q, frame_dp_d;
  logic [NDIG-1:0]   frame_bad_q, frame_bad_d;
  logic              latch;

  // Committed digits overwrite their staging slot. This happens even while
  // a frame is pending, because the presented outputs are separate registers.
  always_comb begin
    stg_hex_d = stg_hex_q;
    stg_dp_d  = stg_dp_q;
    stg_bad_d = stg_bad_q;
    for (int k = 0; k < NDIG; k++) begin
      if (commit[k]) begin
        stg_hex_d[4*k +: 4] = enc_w[3:0];
        stg_bad_d[k]        = enc_w[4];
        stg_dp_d[k]         = dp_q;
      end
    end
  end

  // Latch a new frame once every digit has committed and the output slot is
  // free or being emptied on this edge. The copy uses the staging values
  // from before this edge. A digit that commits on the latch edge therefore
  // keeps its done bit and counts toward the next frame.
  always_comb begin
    latch         = (&done_q) && (!frame_valid_q || frame_ready);
    done_d        = (latch ? '0 : done_q) | commit;
    frame_valid_d = frame_valid_q;
    frame_hex_d   = frame_hex_q;
    frame_dp_d    = frame_dp_q;
    frame_bad_d   = frame_bad_q;
    if (latch) begin
      frame_valid_d = 1'b1;
      frame_hex_d   = stg_hex_q;
      frame_dp_d    = stg_dp_q;
      frame_bad_d   = stg_bad_q;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  // Staging, done flags and the presented frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_hex_q     <= '0;
      stg_dp_q      <= '0;
      stg_bad_q     <= '0;
      done_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_hex_q   <= '0;
      frame_dp_q    <= '0;
      frame_bad_q   <= '0;
    end else begin
      stg_hex_q     <= stg_hex_d;
      stg_dp_q      <= stg_dp_d;
      stg_bad_q     <= stg_bad_d;
      done_q        <= done_d;
      frame_valid_q <= frame_valid_d;
      frame_hex_q   <= frame_hex_d;
      frame_dp_q    <= frame_dp_d;
      frame_bad_q   <= frame_bad_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_hex   = frame_hex_q;
  assign frame_dp    = frame_dp_q;
  assign frame_bad   = frame_bad_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus randomized traffic. Every
// output is compared each cycle against a sample-level reference model.
module tb_seg_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

`ifdef SEG_CAPTURE_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  // ---------------- clock / reset / pins ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_p = 1'b1;
  logic [6:0] seg_p = '0;
  logic       dp_p  = 1'b0;
  logic [3:0] en_p  = '0;
  logic       rdy   = 1'b0;

  logic [6:0]  seg_w;
  logic        dp_w;
  logic [3:0]  en_w;
  logic        frame_valid;
  logic [15:0] frame_hex;
  logic [3:0]  frame_dp;
  logic [3:0]  frame_bad;

  assign seg_w = INV ? ~seg_p : seg_p;
  assign dp_w  = INV ? ~dp_p  : dp_p;
  assign en_w  = INV ? ~en_p  : en_p;

  seg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk         (clk),
    .rst         (rst_p),
    .seg         (seg_w),
    .dp          (dp_w),
    .dig_en      (en_w),
    .frame_valid (frame_valid),
    .frame_ready (rdy),
    .frame_hex   (frame_hex),
    .frame_dp    (frame_dp),
    .frame_bad   (frame_bad)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pattern -> nibble lookup built from the display code table; -1 = unknown.
  int lut[128];
  logic [6:0] code_tab[16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Pins as seen one edge ago (the sample that reaches the counters now).
  logic [6:0] mr_seg;
  logic       mr_dp;
  logic [3:0] mr_en;
  // Per digit: last pattern seen, run length since change/commit, done flag.
  logic [6:0] m_last[4];
  bit         m_last_dp[4];
  int         m_run[4];
  bit         m_done[4];
  int         m_stg_nib[4];
  bit         m_stg_dp[4];
  bit         m_stg_bad[4];
  bit         m_valid;
  int         m_nib[4];
  bit         m_fdp[4];
  bit         m_fbad[4];

  function automatic void model_reset();
    mr_seg = '0; mr_dp = 1'b0; mr_en = '0; m_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_last[k] = '0; m_last_dp[k] = 1'b0; m_run[k] = 0; m_done[k] = 1'b0;
      m_stg_nib[k] = 0; m_stg_dp[k] = 1'b0; m_stg_bad[k] = 1'b0;
      m_nib[k] = 0; m_fdp[k] = 1'b0; m_fbad[k] = 1'b0;
    end
  endfunction

  // Apply one rising edge to the model, using the pin values present at it.
  function automatic void model_edge();
    bit all_done;
    int ones;
    int act;
    if (rst_p) begin
      model_reset();
      return;
    end
    all_done = 1'b1;
    for (int k = 0; k < 4; k++) if (!m_done[k]) all_done = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (all_done && (!m_valid || rdy)) begin
      m_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        m_nib[k] = m_stg_nib[k]; m_fdp[k] = m_stg_dp[k]; m_fbad[k] = m_stg_bad[k];
        m_done[k] = 1'b0;
      end
    end
    ones = 0; act = 0;
    for (int k = 0; k < 4; k++) if (mr_en[k]) begin ones++; act = k; end
    if (ones == 1) begin
      if (mr_seg == m_last[act] && mr_dp == m_last_dp[act]) begin
        m_run[act]++;
      end else begin
        m_last[act] = mr_seg; m_last_dp[act] = mr_dp; m_run[act] = 1;
      end
      if (m_run[act] == STABLE) begin
        m_run[act] = 0;
        m_done[act] = 1'b1;
        m_stg_dp[act] = mr_dp;
        if (lut[mr_seg] < 0) begin
          m_stg_nib[act] = 0; m_stg_bad[act] = 1'b1;
        end else begin
          m_stg_nib[act] = lut[mr_seg]; m_stg_bad[act] = 1'b0;
        end
      end
    end
    mr_seg = seg_p; mr_dp = dp_p; mr_en = en_p;
  endfunction

  // ---------------- cycle step and drivers ----------------
  logic [23:0] xfer_q[$];   // transferred frames {bad, dp, hex}
  bit          valid_seen;

  task automatic tick();
    logic        was_valid;
    logic [23:0] was_frame;
    logic [15:0] eh;
    logic [3:0]  ed, eb;
    was_valid = frame_valid;
    was_frame = {frame_bad, frame_dp, frame_hex};
    @(posedge clk);
    if (!rst_p && was_valid === 1'b1 && rdy) xfer_q.push_back(was_frame);
    model_edge();
    #1;
    if (frame_valid === 1'b1) valid_seen = 1'b1;
    eh = '0; ed = '0; eb = '0;
    for (int k = 0; k < 4; k++) begin
      eh[4*k +: 4] = 4'(m_nib[k]);
      ed[k] = m_fdp[k];
      eb[k] = m_fbad[k];
    end
    chk("valid", {31'd0, frame_valid}, {31'd0, m_valid});
    chk("hex",   {16'd0, frame_hex},   {16'd0, eh});
    chk("dp",    {28'd0, frame_dp},    {28'd0, ed});
    chk("bad",   {28'd0, frame_bad},   {28'd0, eb});
  endtask

  task automatic drive(input logic [6:0] s, input logic d, input logic [3:0] e);
    seg_p = s; dp_p = d; en_p = e;
    tick();
  endtask

  task automatic reset_dut();
    rst_p = 1'b1; seg_p = '0; dp_p = 1'b0; en_p = '0;
    tick();
    tick();
    rst_p = 1'b0;
  endtask

  logic [6:0] cur_pat[4];
  logic       cur_dp[4];

  task automatic set_std();
    cur_pat[0] = 7'h30; cur_pat[1] = 7'h6D; cur_pat[2] = 7'h79; cur_pat[3] = 7'h33;
    for (int k = 0; k < 4; k++) cur_dp[k] = 1'b0;
  endtask

  // Round-robin scan of masked digits. The noise option inserts ignored
  // samples (no enable or two enables) before legal ones.
  task automatic scan(input int rounds, input logic [3:0] mask, input bit noise);
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) begin
          if (noise && $urandom_range(0, 1) == 1)
            drive(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'b0101);
          drive(cur_pat[k], cur_dp[k], 4'(1 << k));
        end
      end
    end
  endtask

  // Idle until n frames have transferred, bounded by budget cycles.
  task automatic wait_xfer(input string tag, input int n, input int budget, output int used);
    used = 0;
    while (xfer_q.size() < n && used < budget) begin
      drive(7'h00, 1'b0, 4'b0000);
      used++;
    end
    chk(tag, {31'd0, xfer_q.size() >= n}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] pool[19] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
                           7'h00, 7'h01, 7'h7C};

  initial begin
    int lat1, lat4, used, rr, x;
    logic [3:0] e;
    logic [6:0] rp[4];
    logic       rdp[4];

    for (int i = 0; i < 128; i++) lut[i] = -1;
    for (int i = 0; i < 16; i++) lut[code_tab[i]] = i;
    model_reset();

    // Reset state.
    reset_dut();
    chk("rst_state_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_state_hex", {16'd0, frame_hex}, 32'd0);

    // Clean scan -> 0x4321; transfer 3 idle edges after the last sample.
    rdy = 1'b1; set_std(); xfer_q.delete();
    scan(3, 4'b1111, 1'b0);
    wait_xfer("sc1_timeout", 1, 20, lat1);
    if (xfer_q.size() > 0) begin
      chk("sc1_hex", {16'd0, xfer_q[0][15:0]}, 32'h4321);
      chk("sc1_dp",  {28'd0, xfer_q[0][19:16]}, 32'd0);
      chk("sc1_bad", {28'd0, xfer_q[0][23:20]}, 32'd0);
    end
    chk("sc1_latency", lat1, 32'd3);

    // Digit 2 toggling never completes a frame; steady 7F then gives 8.
    reset_dut(); set_std(); valid_seen = 1'b0;
    for (int r = 0; r < 6; r++) begin
      cur_pat[2] = (r % 2 == 0) ? 7'h7E : 7'h7F;
      scan(1, 4'b1111, 1'b0);
    end
    chk("toggle_no_frame", {31'd0, valid_seen}, 32'd0);
    cur_pat[2] = 7'h7F; xfer_q.delete();
    scan(3, 4'b1111, 1'b0);
    wait_xfer("sc2_timeout", 1, 20, used);
    if (xfer_q.size() > 0) chk("sc2_nib2", {28'd0, xfer_q[0][11:8]}, 32'd8);

    // Unknown pattern with dp on digit 1.
    reset_dut(); set_std(); cur_pat[1] = 7'h01; cur_dp[1] = 1'b1; xfer_q.delete();
    scan(3, 4'b1111, 1'b0);
    wait_xfer("sc3_timeout", 1, 20, used);
    if (xfer_q.size() > 0) begin
      chk("sc3_nib1", {28'd0, xfer_q[0][7:4]}, 32'd0);
      chk("sc3_bad",  {28'd0, xfer_q[0][23:20]}, 32'b0010);
      chk("sc3_dp",   {28'd0, xfer_q[0][19:16]}, 32'b0010);
    end

    // Illegal enables interleaved: same frame, same latency.
    reset_dut(); set_std(); xfer_q.delete();
    scan(3, 4'b1111, 1'b1);
    wait_xfer("sc4_timeout", 1, 20, lat4);
    if (xfer_q.size() > 0) chk("sc4_hex", {16'd0, xfer_q[0][15:0]}, 32'h4321);
    chk("sc4_latency", lat4, lat1);

    // Backpressure: pending frame holds while digit 0 changes to 47.
    reset_dut(); set_std(); rdy = 1'b0; xfer_q.delete();
    scan(3, 4'b1111, 1'b0);
    used = 0;
    while (frame_valid !== 1'b1 && used < 20) begin drive(7'h00, 1'b0, 4'b0000); used++; end
    chk("sc5_valid", {31'd0, frame_valid}, 32'd1);
    cur_pat[0] = 7'h47;
    scan(5, 4'b1111, 1'b0);
    chk("sc5_hold_hex", {16'd0, frame_hex}, 32'h4321);
    rdy = 1'b1;
    wait_xfer("sc5_timeout", 2, 20, used);
    if (xfer_q.size() > 1) begin
      chk("sc5_first_hex", {16'd0, xfer_q[0][15:0]}, 32'h4321);
      chk("sc5_next_nib0", {28'd0, xfer_q[1][3:0]}, 32'hF);
    end

    // Reset after two digits commit discards partial progress.
    reset_dut(); set_std();
    scan(3, 4'b0011, 1'b0);
    for (int i = 0; i < 3; i++) drive(7'h00, 1'b0, 4'b0000);
    rst_p = 1'b1; tick(); rst_p = 1'b0;
    chk("sc6_rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("sc6_rst_hex", {16'd0, frame_hex}, 32'd0);
    valid_seen = 1'b0;
    scan(3, 4'b1100, 1'b0);
    for (int i = 0; i < 5; i++) drive(7'h00, 1'b0, 4'b0000);
    chk("sc6_no_partial_frame", {31'd0, valid_seen}, 32'd0);
    xfer_q.delete();
    scan(3, 4'b0011, 1'b0);
    wait_xfer("sc6_timeout", 1, 20, used);
    if (xfer_q.size() > 0) chk("sc6_hex", {16'd0, xfer_q[0][15:0]}, 32'h4321);

    // Randomized traffic against the model.
    for (int k = 0; k < 4; k++) begin rp[k] = pool[$urandom_range(0, 18)]; rdp[k] = 1'b0; end
    rr = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_dut();
      end else begin
        if ($urandom_range(0, 99) < 8) begin
          x = $urandom_range(0, 3);
          rp[x] = pool[$urandom_range(0, 18)];
          rdp[x] = ($urandom_range(0, 7) == 0);
        end
        rdy = ($urandom_range(0, 3) != 0);
        x = $urandom_range(0, 9);
        if (x < 8) begin
          rr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : (rr + 1) % 4;
          drive(rp[rr], rdp[rr], 4'(1 << rr));
        end else begin
          e = (x == 8) ? 4'b0000 : 4'($urandom_range(0, 15));
          drive(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), e);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Receive-side counterpart to the hex-to-seven-segment decoder. The block samples a multiplexed seven-segment bus (segments a..g, dp, one-hot digit enables) and requires each digit's pattern to be stable before converting it back to a hex nibble. Captured digits are assembled into complete frames and handed downstream through a valid/ready handshake. It sits in the test/monitor path, reading back what the display drivers actually emit.

## Interface
- NDIG, 4: number of multiplexed digits; width of `dig_en`; ≥1.
- STABLE, 3: consecutive identical active samples required to commit a digit; ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg  in  7  segment levels, ordered {a,b,c,d,e,f,g}; a is the MSB.
- dp  in  1  decimal-point level.
- dig_en  in  NDIG  digit enables; bit k selects digit k; legal only when one-hot.
- frame_valid  out  1  a complete frame is presented.
- frame_ready  in  1  downstream accepts the frame.
- frame_hex  out  4*NDIG  nibble k at bits [4k+3:4k].
- frame_dp  out  NDIG  captured dp per digit.
- frame_bad  out  NDIG  bit k set means digit k's pattern was unrecognized.

## Operation
- Input stage: `seg`, `dp` and `dig_en` are registered (`seg_q`, `dp_q`, `en_q`) before any use.
- Sample filter: the registered sample is used only when `en_q` is exactly one-hot.
  - All-zero or multi-hot `en_q`: the sample is ignored; no per-digit state changes.
- Per-digit state k: `last_pat[k]` (7 bits), `last_dp[k]`, `cnt[k]` of width $clog2(STABLE+1), and `done[k]`.
- Active digit k, each legal sample:
  - If {seg_q,dp_q} equals {last_pat[k],last_dp[k]}: cnt[k]+1.
  - Otherwise: store the new pattern and set cnt[k]=1.
- Commit: on the edge where cnt[k] would reach STABLE:
  - write the nibble, dp and bad bit for digit k into a staging register;
  - set done[k];
  - return cnt[k] to 0.
  - A steady display therefore recommits every STABLE active samples.
- Encode table (pattern→nibble, hex pattern values):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
  - Any other pattern → nibble 0 with bad=1.
- Frame assembly: latch is permitted when all done bits are set and (!frame_valid or frame_ready).
  - On latch: copy the staging register to the frame outputs, set frame_valid, clear all done bits.
- Same-edge latch and commit of digit k: staging k receives the new value after the copy; done[k] ends at 1, counting toward the next frame.
- Digits re-committed while a frame is pending overwrite staging only. Presented frame outputs never change while frame_valid=1.

## Timing
- Reset values: frame_valid=0, frame_hex=0, frame_dp=0, frame_bad=0; all cnt, last_pat, last_dp, done and staging registers = 0; input registers = 0.
- Commit latency: the STABLE-th consecutive identical active sample on the pins commits 2 edges after it is presented (input register + counter).
- Frame latency: frame_valid rises on the edge after the last digit's commit edge.
- Handshake:
  - Transfer occurs on an edge with frame_valid=1 and frame_ready=1.
  - frame_valid drops on that edge unless a new frame latches on the same edge (back-to-back frames allowed).
  - frame_ready is ignored while frame_valid=0.
- Interleaving other digits does not reset a digit's count; only a differing pattern on that digit does.
- Reset mid-frame discards all partial state; the first frame after reset needs a full STABLE commit for every digit.

## Configuration
- SEG_CAPTURE_ACTIVE_LOW_EN defined: `seg`, `dp` and `dig_en` are inverted at the input register (common-anode bus).
  - The encode table and all downstream logic still operate on active-high values.
- Undefined: inputs are used as active-high directly.

## Test plan
- Reset, then scan digits 0..3 with 30,6D,79,33 (dp=0), 3 samples each, round-robin -> one frame: frame_hex=0x4321, frame_bad=0, frame_dp=0.
- Digit 2 pattern toggles 7E/7F every sample, other digits steady -> frame_valid never rises; steady 7F afterwards -> frame_hex[11:8]=8.
- Digit 1 shows 01 with dp=1 -> frame_hex[7:4]=0, frame_bad=4'b0010, frame_dp=4'b0010.
- dig_en=4'b0000 and 4'b0101 interleaved between legal samples -> counts unchanged; frame timing identical to the clean scan.
- frame_ready held 0 for 20 cycles while digit 0 changes 30→47 -> frame_hex stays 0x4321; on ready=1, the next frame shows nibble 0=F.
- rst asserted after two digits committed -> all outputs 0 next edge; no frame until all 4 digits recommit.
